// File: rtl/shift_register_tap_arbiter.sv
// Dynamic-tap delay line whose single read port is shared round-robin
// between NUM_REQ tap readers, with fill tracking and tagged responses.

// Shift register with one random-access read port and a registered output.
module shift_register_dynamic #(
  parameter int unsigned DATA_WIDTH          = 16,
  parameter int unsigned DEPTH               = 32,
  parameter int unsigned NUM_REGISTER_OUTPUT = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [DATA_WIDTH-1:0]    din,
  input  logic                     reb,
  input  logic                     clrb,
  input  logic [$clog2(DEPTH)-1:0] addrb,
  output logic [DATA_WIDTH-1:0]    doutb
);

  logic [DATA_WIDTH-1:0] mem_q  [DEPTH];
  logic [DATA_WIDTH-1:0] dout_q [NUM_REGISTER_OUTPUT];

  // Sample storage: not reset, a push moves every entry one tap deeper.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[0] <= din;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        mem_q[i] <= mem_q[i-1];
      end
    end
  end

  // Output register captures the pre-shift tap; clrb forces a zero word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGISTER_OUTPUT; i++) begin
        dout_q[i] <= '0;
      end
    end else begin
      if (reb) begin
        dout_q[0] <= clrb ? '0 : mem_q[addrb];
      end
      for (int unsigned i = 1; i < NUM_REGISTER_OUTPUT; i++) begin
        dout_q[i] <= dout_q[i-1];
      end
    end
  end

  assign doutb = dout_q[NUM_REGISTER_OUTPUT-1];

endmodule

// Round-robin tap-read arbiter around the shift register.
module shift_register_tap_arbiter #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned NUM_REQ    = 4
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               wr_valid,
  input  logic [DATA_WIDTH-1:0]              wr_data,
  input  logic                               flush,
  input  logic [NUM_REQ-1:0]                 req_valid,
  input  logic [NUM_REQ*$clog2(DEPTH)-1:0]   req_tap,
  output logic [NUM_REQ-1:0]                 req_ready,
  output logic                               rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0]         rsp_id,
  output logic [DATA_WIDTH-1:0]              rsp_data,
  output logic                               rsp_err,
  output logic [$clog2(DEPTH):0]             fill_count,
  output logic                               full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned IW = $clog2(NUM_REQ);

  logic [AW:0]    fill_q, fill_d;
  logic [IW-1:0]  last_grant_q, last_grant_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [IW-1:0]  rsp_id_q, rsp_id_d;
  logic           rsp_err_q, rsp_err_d;

  logic [AW-1:0]      tap_arr [NUM_REQ];
  logic               grant_c;
  logic [IW-1:0]      winner_c;
  logic [AW-1:0]      win_tap_c;
  logic               err_c;
  logic [NUM_REQ-1:0] ready_c;
  int unsigned        idx;

  // Unpack the per-requester tap indices.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_tap
    assign tap_arr[g] = req_tap[g*AW +: AW];
  end

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    grant_c   = 1'b0;
    winner_c  = '0;
    win_tap_c = '0;
    ready_c   = '0;
    idx       = 0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      idx = 32'(last_grant_q) + off;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (!grant_c && req_valid[IW'(idx)]) begin
        grant_c            = 1'b1;
        winner_c           = IW'(idx);
        win_tap_c          = tap_arr[IW'(idx)];
        ready_c[IW'(idx)]  = 1'b1;
      end
    end
    if (!reset_n) begin
      grant_c = 1'b0;
      ready_c = '0;
    end
  end

  // A tap at or beyond the pre-update fill level has never been written.
  assign err_c = ({1'b0, win_tap_c} >= fill_q);

  // Next-state for fill level, arbitration pointer and response tag.
  always_comb begin
    fill_d       = fill_q;
    last_grant_d = last_grant_q;
    rsp_valid_d  = grant_c;
    rsp_id_d     = rsp_id_q;
    rsp_err_d    = rsp_err_q;
    if (flush) begin
      fill_d = '0;
    end else if (wr_valid && (fill_q != (AW+1)'(DEPTH))) begin
      fill_d = fill_q + 1'b1;
    end
    if (grant_c) begin
      last_grant_d = winner_c;
      rsp_id_d     = winner_c;
      rsp_err_d    = err_c;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fill_q       <= '0;
      last_grant_q <= IW'(NUM_REQ - 1);
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      fill_q       <= fill_d;
      last_grant_q <= last_grant_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  shift_register_dynamic #(
    .DATA_WIDTH          (DATA_WIDTH),
    .DEPTH               (DEPTH),
    .NUM_REGISTER_OUTPUT (1)
  ) u_sr (
    .clk   (clk),
    .rst_n (reset_n),
    .we    (wr_valid),
    .din   (wr_data),
    .reb   (grant_c),
    .clrb  (err_c),
    .addrb (win_tap_c),
    .doutb (rsp_data)
  );

  assign req_ready  = ready_c;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_err    = rsp_err_q;
  assign fill_count = fill_q;
  assign full       = (fill_q == (AW+1)'(DEPTH));

endmodule

// File: tb/tb_shift_register_tap_arbiter.sv
// Directed vector bench for shift_register_tap_arbiter (DEPTH=32, NUM_REQ=4).
module tb_shift_register_tap_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wr_valid;
  logic [15:0] wr_data;
  logic        flush;
  logic [3:0]  req_valid;
  logic [19:0] req_tap;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic [5:0]  fill_count;
  logic        full;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        rst;
    logic        wv;
    logic [15:0] wd;
    logic        fl;
    logic [3:0]  rv;
    logic [19:0] taps;
    logic [3:0]  rdy;
    logic        vld;
    logic [1:0]  id;
    logic        err;
    logic [15:0] data;
    logic [5:0]  fill;
  } vec_t;

  vec_t vq[$];

  always #5 clk = ~clk;

  shift_register_tap_arbiter #(
    .DATA_WIDTH (16),
    .DEPTH      (32),
    .NUM_REQ    (4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_tap    (req_tap),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .fill_count (fill_count),
    .full       (full)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [19:0] pk(input logic [4:0] t0, input logic [4:0] t1,
                                     input logic [4:0] t2, input logic [4:0] t3);
    return {t3, t2, t1, t0};
  endfunction

  task automatic add(input logic rst, input logic wv, input logic [15:0] wd, input logic fl,
                     input logic [3:0] rv, input logic [19:0] taps, input logic [3:0] rdy,
                     input logic vld, input logic [1:0] id, input logic err,
                     input logic [15:0] data, input logic [5:0] fill);
    vec_t v;
    v.rst = rst; v.wv = wv; v.wd = wd; v.fl = fl; v.rv = rv; v.taps = taps;
    v.rdy = rdy; v.vld = vld; v.id = id; v.err = err; v.data = data; v.fill = fill;
    vq.push_back(v);
  endtask

  task automatic push(input logic rst, input logic [15:0] d, input logic [5:0] fill);
    add(rst, 1'b1, d, 1'b0, 4'h0, 20'h0, 4'h0, 1'b0, 2'd0, 1'b0, 16'h0, fill);
  endtask

  // Ends one time unit after a rising edge with reset released.
  task automatic do_reset();
    reset_n   = 1'b0;
    wr_valid  = 1'b0;
    wr_data   = 16'h0;
    flush     = 1'b0;
    req_valid = 4'h0;
    req_tap   = 20'h0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    // Round robin with every requester pending; empty line so all err.
    for (int i = 0; i < 8; i++)
      add(i == 0, 1'b0, 16'h0, 1'b0, 4'hF, 20'h0, 4'(1 << (i % 4)), 1'b1, 2'(i % 4),
          1'b1, 16'h0, 6'd0);
    // Push 1..5, read taps 0..5 from requester 0.
    for (int d = 1; d <= 5; d++) push(d == 1, 16'(d), 6'(d));
    for (int k = 0; k <= 5; k++)
      add(1'b0, 1'b0, 16'h0, 1'b0, 4'h1, pk(5'(k), 5'd0, 5'd0, 5'd0), 4'h1, 1'b1, 2'd0,
          k == 5, (k == 5) ? 16'h0 : 16'(5 - k), 6'd5);
    // Pointer rotation with sparse requests (last grant = 0).
    add(1'b0, 1'b0, 16'h0, 1'b0, 4'b1010, pk(5'd0, 5'd1, 5'd0, 5'd4), 4'b0010, 1'b1, 2'd1,
        1'b0, 16'd4, 6'd5);
    add(1'b0, 1'b0, 16'h0, 1'b0, 4'b1001, pk(5'd6, 5'd0, 5'd0, 5'd4), 4'b1000, 1'b1, 2'd3,
        1'b0, 16'd1, 6'd5);
    add(1'b0, 1'b0, 16'h0, 1'b0, 4'b0011, pk(5'd6, 5'd1, 5'd0, 5'd0), 4'b0001, 1'b1, 2'd0,
        1'b1, 16'h0, 6'd5);
    add(1'b0, 1'b0, 16'h0, 1'b0, 4'b0000, 20'h0, 4'b0000, 1'b0, 2'd0, 1'b0, 16'h0, 6'd5);
    // Same-cycle push and read sees pre-shift contents and pre-push fill.
    push(1'b1, 16'h11, 6'd1);
    push(1'b0, 16'h22, 6'd2);
    push(1'b0, 16'h33, 6'd3);
    add(1'b0, 1'b1, 16'hAA, 1'b0, 4'b0001, pk(5'd0, 5'd0, 5'd0, 5'd0), 4'b0001, 1'b1, 2'd0,
        1'b0, 16'h33, 6'd4);
    add(1'b0, 1'b1, 16'hBB, 1'b0, 4'b0010, pk(5'd0, 5'd4, 5'd0, 5'd0), 4'b0010, 1'b1, 2'd1,
        1'b1, 16'h0, 6'd5);
    add(1'b0, 1'b1, 16'hCC, 1'b0, 4'b0100, pk(5'd0, 5'd0, 5'd4, 5'd0), 4'b0100, 1'b1, 2'd2,
        1'b0, 16'h11, 6'd6);
    // Flush beats a simultaneous push; read in flush cycle uses old count.
    for (int d = 1; d <= 10; d++) push(d == 1, 16'(d), 6'(d));
    add(1'b0, 1'b1, 16'h77, 1'b1, 4'b0001, pk(5'd9, 5'd0, 5'd0, 5'd0), 4'b0001, 1'b1, 2'd0,
        1'b0, 16'd1, 6'd0);
    add(1'b0, 1'b0, 16'h0, 1'b0, 4'b0010, pk(5'd0, 5'd0, 5'd0, 5'd0), 4'b0010, 1'b1, 2'd1,
        1'b1, 16'h0, 6'd0);
    // Saturation at DEPTH; deepest tap only readable when full.
    for (int d = 1; d <= 40; d++) begin
      if (d == 32)
        add(1'b0, 1'b1, 16'(d), 1'b0, 4'b0001, pk(5'd31, 5'd0, 5'd0, 5'd0), 4'b0001, 1'b1,
            2'd0, 1'b1, 16'h0, 6'd32);
      else
        push(d == 1, 16'(d), 6'((d > 32) ? 32 : d));
    end
    add(1'b0, 1'b0, 16'h0, 1'b0, 4'b0001, pk(5'd31, 5'd0, 5'd0, 5'd0), 4'b0001, 1'b1, 2'd0,
        1'b0, 16'd9, 6'd32);
    add(1'b0, 1'b0, 16'h0, 1'b0, 4'b0001, pk(5'd0, 5'd0, 5'd0, 5'd0), 4'b0001, 1'b1, 2'd0,
        1'b0, 16'd40, 6'd32);

    // Reset state: no grant while reset is held even with requests pending.
    reset_n   = 1'b0;
    wr_valid  = 1'b0;
    wr_data   = 16'h0;
    flush     = 1'b0;
    req_tap   = 20'h0;
    req_valid = 4'hF;
    #2;
    check("reset req_ready", 32'(req_ready), 32'h0);
    do_reset();
    check("reset fill_count", 32'(fill_count), 32'd0);
    check("reset full", 32'(full), 32'd0);
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset rsp_id", 32'(rsp_id), 32'd0);
    check("reset rsp_err", 32'(rsp_err), 32'd0);
    check("reset rsp_data", 32'(rsp_data), 32'd0);

    foreach (vq[i]) begin
      if (vq[i].rst) do_reset();
      wr_valid  = vq[i].wv;
      wr_data   = vq[i].wd;
      flush     = vq[i].fl;
      req_valid = vq[i].rv;
      req_tap   = vq[i].taps;
      #1;
      check($sformatf("v%0d req_ready", i), 32'(req_ready), 32'(vq[i].rdy));
      @(posedge clk);
      #1;
      check($sformatf("v%0d fill_count", i), 32'(fill_count), 32'(vq[i].fill));
      check($sformatf("v%0d full", i), 32'(full), 32'(vq[i].fill == 6'd32));
      check($sformatf("v%0d rsp_valid", i), 32'(rsp_valid), 32'(vq[i].vld));
      if (vq[i].vld) begin
        check($sformatf("v%0d rsp_id", i), 32'(rsp_id), 32'(vq[i].id));
        check($sformatf("v%0d rsp_err", i), 32'(rsp_err), 32'(vq[i].err));
        check($sformatf("v%0d rsp_data", i), 32'(rsp_data), 32'(vq[i].data));
      end
    end

    // Reset asserted mid-cycle after a grant drops the response.
    wr_valid  = 1'b0;
    flush     = 1'b0;
    req_valid = 4'b0010;
    req_tap   = 20'h0;
    #1;
    check("midrst grant", 32'(req_ready), 32'b0010);
    #2 reset_n = 1'b0;
    #1;
    check("midrst req_ready", 32'(req_ready), 32'h0);
    @(posedge clk);
    #1;
    check("midrst rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst fill_count", 32'(fill_count), 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    req_valid = 4'hF;
    #1;
    check("post-rst priority", 32'(req_ready), 32'b0001);
    check("post-rst fill_count", 32'(fill_count), 32'd0);
    check("post-rst full", 32'(full), 32'd0);
    check("post-rst rsp_data", 32'(rsp_data), 32'd0);
    @(posedge clk);
    #1;
    req_valid = 4'h0;
    check("post-rst rsp_valid", 32'(rsp_valid), 32'd1);
    check("post-rst rsp_id", 32'(rsp_id), 32'd0);
    check("post-rst rsp_err", 32'(rsp_err), 32'd1);
    check("post-rst rsp_data zero", 32'(rsp_data), 32'd0);
    @(posedge clk);
    #1;
    check("post-rst pulse", 32'(rsp_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_register_tap_arbiter.md
# shift_register_tap_arbiter

Shares the single read port of a dynamic-tap shift register (internal `shift_register_dynamic` instance, NUM_REGISTER_OUTPUT = 1) between NUM_REQ requesters, each reading an arbitrary tap. It tracks the fill level so that taps not yet written return an error instead of stale data. It arbitrates round-robin, one read per cycle, and returns tagged responses one cycle after grant. It sits between a sample producer (delay-line writer) and multiple tap consumers, e.g. FIR/correlator tap readers.

## Interface
- DATA_WIDTH, 16, sample width.
- DEPTH, 32, shift register depth; power of two, ≥ 2.
- NUM_REQ, 4, number of requesters; 2..16.
- AW = $clog2(DEPTH); IW = $clog2(NUM_REQ) (derived localparams).

- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- wr_valid  in  1  push wr_data onto tap 0 this cycle.
- wr_data  in  DATA_WIDTH  sample to push.
- flush  in  1  clears fill level (data contents untouched).
- req_valid  in  NUM_REQ  per-requester read request.
- req_tap  in  NUM_REQ*AW  packed tap indices; requester i uses bits [i*AW +: AW].
- req_ready  out  NUM_REQ  one-hot grant; a transfer occurs on req_valid[i] & req_ready[i].
- rsp_valid  out  1  response valid (no backpressure).
- rsp_id  out  IW  requester index of the response.
- rsp_data  out  DATA_WIDTH  tap data; 0 when rsp_err.
- rsp_err  out  1  requested tap ≥ fill level at grant.
- fill_count  out  AW+1  valid entries, saturating at DEPTH.
- full  out  1  fill_count == DEPTH.

## Operation
- Push: wr_valid=1 shifts the register; wr_data becomes tap 0 after the edge. fill_count increments, saturating at DEPTH. Pushes are never stalled.
- Tap semantics: a granted read of tap k in cycle N returns the sample pushed k+1 pushes before the edge ending N. A push in the same cycle N is not visible; the read sees the pre-shift contents.
- Fill check at grant: err = (req_tap ≥ fill_count) using the pre-update fill_count of cycle N. On err, rsp_data = 0, rsp_err = 1, and the response is still issued.
- flush=1: fill_count goes to 0 at the edge and takes priority over a simultaneous push, so the count is 0, not 1. Reads granted in the flush cycle use the pre-flush count.
- Arbitration is round-robin with pointer last_grant:
  - Search order is last_grant+1 … NUM_REQ-1, 0 … last_grant; the first asserted req_valid wins.
  - req_ready is combinational from req_valid and last_grant, and is zero when no request is pending.
  - last_grant updates to the winner only on a grant.
  - At most one grant per cycle.
  - A requester holding req_valid is granted within NUM_REQ cycles.
- Read port drive: addrb = winner's tap (combinational) and reb = any grant. The internal output register captures at the edge ending cycle N.
- Response pipeline: rsp_id, rsp_err and the rsp_valid flag are registered alongside the read data.
- Requesters may change req_tap freely while not granted.

## Timing
- Grant is combinational in cycle N. rsp_valid/rsp_id/rsp_err/rsp_data are valid in cycle N+1, which is fixed 1-cycle latency.
- Throughput: one response per cycle with back-to-back grants.
- rsp_valid is a single-cycle pulse per grant. Without a grant in N, rsp_valid=0 in N+1, and rsp_data holds its last value (don't care).
- Reset (async assert, sync release) values:
  - fill_count=0, full=0
  - last_grant=NUM_REQ-1, so requester 0 has first priority
  - rsp_valid=0, rsp_id=0, rsp_err=0, rsp_data=0
  - req_ready=0 while reset_n=0
- Reset mid-operation: an in-flight response is dropped (rsp_valid=0 in the following cycle). Shift register storage is not reset, but all taps read as err until rewritten.
- Boundaries:
  - tap DEPTH-1 is readable only when full.
  - At fill_count=DEPTH a push keeps the count at DEPTH; the oldest sample is discarded.
  - A push and read in the same cycle at fill_count=k allows tap k-1 read OK; tap k returns err.

## Test plan
- After reset, push 0x0001..0x0005 on consecutive cycles. Requester 0 reads taps 0..4 -> rsp_data 0x0005, 0x0004 … 0x0001, all rsp_err=0; tap 5 -> rsp_err=1, rsp_data=0; rsp_valid exactly one cycle after each grant.
- All 4 requesters hold req_valid for 8 cycles after reset -> grant order 0,1,2,3,0,1,2,3; rsp_id follows one cycle later; one rsp_valid per cycle.
- Push 40 samples 1..40 with DEPTH=32 -> fill_count=32, full=1; tap 31 returns 9, tap 0 returns 40.
- With fill_count=3, push 0x00AA while granting tap 0 in the same cycle -> response is the pre-push tap 0 sample. Tap 3 requested in that cycle -> rsp_err=1.
- Assert flush together with wr_valid at fill_count=10 -> fill_count=0 next cycle; a tap 0 read in the next cycle -> rsp_err=1.
- Grant a read, then assert reset_n=0 mid-cycle -> rsp_valid stays 0. After release: fill_count=0, requester 0 has priority, and any read -> rsp_err=1.
